wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Shares the single register-file write port between the three result producers: ALU, MEM and CSR.
- Each source gets a 1-entry holding slot with a valid/ready handshake, so a losing producer stalls instead of dropping its result.
- An arbiter picks one occupied slot per cycle and presents it to the register manager.
- A CSR exception flush discards all pending results.
- Sits between the execute/memory/CSR stages and the register manager, replacing the purely combinational result select.

Parameters:
- XLEN, 32, data width of results; the package constant xlen is passed in.
- NSRC, 3, number of sources; fixed at 3, index 0=MEM, 1=CSR, 2=ALU.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- alu_res  in  XLEN  ALU result
- alu_rd  in  5  ALU destination register
- alu_res_v  in  1  ALU result valid
- alu_ready  out  1  ALU slot can accept
- mem_res  in  XLEN  load result
- mem_rd  in  5  load destination register
- mem_res_v  in  1  load result valid
- mem_ready  out  1  MEM slot can accept
- csr_res  in  XLEN  CSR read result
- csr_rd  in  5  CSR destination register
- csr_res_v  in  1  CSR result valid
- csr_ready  out  1  CSR slot can accept
- flush  in  1  CSR exception; discard all pending results
- result  out  XLEN  write data to register manager
- rd  out  5  write address
- result_v  out  1  write enable
- busy  out  1  at least one slot occupied

Behaviour:
- Reset (async, rst=1):
  - all slot valid bits = 0.
  - RR pointer = 0.
  - Outputs driven from this state: result_v=0, busy=0, result=0, rd=0, all *_ready=1.
- Handshake and acceptance:
  - A transfer is accepted on the rising edge when x_res_v && x_ready.
  - x_ready = !flush && (!slot_v[x] || grant[x]), so a slot drained this cycle can be refilled in the same cycle.
  - A transfer with x_rd==0 is accepted and discarded: the slot stays empty and it is never written.
- Latency:
  - Accept at edge N; the slot is valid in cycle N+1.
  - If granted in cycle N+1: result_v=1 in cycle N+1 and the slot clears at edge N+2.
  - Minimum latency is 1 cycle. There is no combinational path from any *_res_v to result_v.
- Output path:
  - grant is one-hot over the occupied slots; at most one is set per cycle.
  - result, rd and result_v are combinational from the granted slot registers only.
  - When no slot is granted: result_v=0 and result/rd hold their last driven values (not X).
- Arbitration (default, fixed priority): MEM > CSR > ALU.
- Flush:
  - While flush=1: result_v=0, all *_ready=0, no grants.
  - At the edge, all slot valid bits clear and the RR pointer is unchanged.
  - Incoming valids in the flush cycle are dropped.
  - flush takes precedence over acceptance and grant in the same cycle.
- busy = OR of the slot valid bits. It is registered-state derived and is used for fence/drain.
- Ordering contract: upstream scoreboard issue guarantees at most one in-flight write per architectural rd. The arbiter does not reorder-check.
- Idle steady state: no valids for one cycle after the last drain -> busy=0.

Optional Feature:
- WB_ARB_RR_EN defined:
  - round-robin arbitration.
  - Search starts at the RR pointer; after a grant to index i, the pointer becomes (i+1) mod 3.
  - The pointer does not move on cycles with no grant.
- WB_ARB_RR_EN undefined:
  - fixed priority MEM > CSR > ALU.
  - No pointer register is synthesized.

Decomposition:
- Shared package cpu_parameters holds:
  - xlen.
  - wb_src_e enum (WB_MEM=0, WB_CSR=1, WB_ALU=2).
  - wb_entry_t struct {logic[xlen-1:0] data; logic[4:0] rd; logic v}.
- One sub-module, wb_slot: a 1-entry holding register with load/clear/flush and ready generation, instantiated three times.
- Arbitration logic stays in wb_arbiter.

Test Plan:
- Reset mid-traffic: assert rst with all three slots full -> next cycle result_v=0, busy=0, all *_ready=1; deassert -> no stale write ever appears.
- Single source: alu_res=0x1234, alu_rd=5, alu_res_v=1 for one cycle -> next cycle result_v=1, rd=5, result=0x1234, then busy=0.
- Three-way collision, fixed priority: all valid in the same cycle with rd 1 (MEM), 2 (CSR), 3 (ALU) -> writes rd=1, then 2, then 3 on consecutive cycles; alu_ready=0 during the two stall cycles.
- Round-robin (WB_ARB_RR_EN defined): all three sources stream back-to-back -> grant order MEM, CSR, ALU, MEM, ...; each source gets exactly 1 of every 3 writes.
- x0 discard: mem_rd=0, mem_res_v=1 -> mem_ready=1, result_v stays 0, busy stays 0.
- Flush: slots MEM and ALU full, flush=1 with csr_res_v=1 -> result_v=0 that cycle; afterwards busy=0, no write for any of the three, and the CSR result is dropped.

Source files
------------

// File: rtl/cpu_parameters.sv
// Shared CPU constants and write-back types used by the result arbiter.
package cpu_parameters;
    localparam int xlen = 32;
    localparam int nsrc = 3;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_CSR = 2'd1,
        WB_ALU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [xlen-1:0] data;
        logic [4:0]      rd;
        logic            v;
    } wb_entry_t;

    // Advance a source index modulo the three producers.
    function automatic logic [1:0] wb_inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a single result producer; a slot drained this
// cycle may be refilled in the same cycle, and writes to x0 are swallowed.
module wb_slot
    import cpu_parameters::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [xlen-1:0] data,
    input  logic [4:0]      rd,
    input  logic            res_v,
    input  logic            grant,
    input  logic            flush,
    output logic            ready,
    output wb_entry_t       entry
);

    wb_entry_t entry_r;
    logic      load_s;

    // Handshake: accept when empty or being drained, never during a flush.
    always_comb begin
        ready  = !flush && (!entry_r.v || grant);
        load_s = res_v && ready && (rd != 5'd0);
    end

    // Slot state: flush beats load, load beats drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_r <= '0;
        end else if (flush) begin
            entry_r.v <= 1'b0;
        end else if (load_s) begin
            entry_r <= '{data: data, rd: rd, v: 1'b1};
        end else if (grant) begin
            entry_r.v <= 1'b0;
        end else begin
            entry_r <= entry_r;
        end
    end

    assign entry = entry_r;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter for MEM, CSR and ALU results.
// Define WB_ARB_RR_EN for round-robin; otherwise fixed priority MEM > CSR > ALU.
module wb_arbiter
    import cpu_parameters::*;
#(
    parameter int XLEN = xlen
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_res,
    input  logic [4:0]      alu_rd,
    input  logic            alu_res_v,
    output logic            alu_ready,
    input  logic [XLEN-1:0] mem_res,
    input  logic [4:0]      mem_rd,
    input  logic            mem_res_v,
    output logic            mem_ready,
    input  logic [XLEN-1:0] csr_res,
    input  logic [4:0]      csr_rd,
    input  logic            csr_res_v,
    output logic            csr_ready,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd,
    output logic            result_v,
    output logic            busy
);

    wb_entry_t       slot_e [nsrc];
    logic [2:0]      ready_s;
    logic [2:0]      grant_s;
    logic [2:0]      occ_s;
    logic [1:0]      gidx_s;
    logic            grant_any_s;
    logic [XLEN-1:0] last_data_r;
    logic [4:0]      last_rd_r;

    wb_slot u_mem (.clk(clk), .rst(rst), .data(mem_res), .rd(mem_rd), .res_v(mem_res_v),
                   .grant(grant_s[WB_MEM]), .flush(flush), .ready(ready_s[WB_MEM]), .entry(slot_e[WB_MEM]));
    wb_slot u_csr (.clk(clk), .rst(rst), .data(csr_res), .rd(csr_rd), .res_v(csr_res_v),
                   .grant(grant_s[WB_CSR]), .flush(flush), .ready(ready_s[WB_CSR]), .entry(slot_e[WB_CSR]));
    wb_slot u_alu (.clk(clk), .rst(rst), .data(alu_res), .rd(alu_rd), .res_v(alu_res_v),
                   .grant(grant_s[WB_ALU]), .flush(flush), .ready(ready_s[WB_ALU]), .entry(slot_e[WB_ALU]));

    assign occ_s     = {slot_e[WB_ALU].v, slot_e[WB_CSR].v, slot_e[WB_MEM].v};
    assign mem_ready = ready_s[WB_MEM];
    assign csr_ready = ready_s[WB_CSR];
    assign alu_ready = ready_s[WB_ALU];
    assign busy      = |occ_s;

`ifdef WB_ARB_RR_EN
    logic [1:0] ptr_r;
    logic [1:0] cand_s;
    logic       found_s;

    // Round-robin pick: first occupied slot at or after the pointer.
    always_comb begin
        grant_s = 3'b000;
        gidx_s  = 2'd0;
        found_s = 1'b0;
        cand_s  = ptr_r;
        for (int k = 0; k < nsrc; k++) begin
            if (!flush && !found_s && occ_s[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                gidx_s          = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
            cand_s = wb_inc3(cand_s);
        end
    end

    // Pointer moves past the winner only on cycles that actually grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 2'd0;
        end else if (grant_any_s) begin
            ptr_r <= wb_inc3(gidx_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority pick: MEM, then CSR, then ALU.
    always_comb begin
        grant_s = 3'b000;
        gidx_s  = 2'd0;
        if (flush) begin
            grant_s = 3'b000;
        end else if (occ_s[WB_MEM]) begin
            grant_s[WB_MEM] = 1'b1;
            gidx_s          = WB_MEM;
        end else if (occ_s[WB_CSR]) begin
            grant_s[WB_CSR] = 1'b1;
            gidx_s          = WB_CSR;
        end else if (occ_s[WB_ALU]) begin
            grant_s[WB_ALU] = 1'b1;
            gidx_s          = WB_ALU;
        end else begin
            grant_s = 3'b000;
        end
    end
`endif

    assign grant_any_s = |grant_s;

    // Remember the last written value so idle cycles keep result/rd stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data_r <= '0;
            last_rd_r   <= 5'd0;
        end else if (grant_any_s) begin
            last_data_r <= slot_e[gidx_s].data;
            last_rd_r   <= slot_e[gidx_s].rd;
        end else begin
            last_data_r <= last_data_r;
            last_rd_r   <= last_rd_r;
        end
    end

    // Output mux driven only from slot registers, never from incoming valids.
    always_comb begin
        result   = last_data_r;
        rd       = last_rd_r;
        result_v = 1'b0;
        if (grant_any_s) begin
            result   = slot_e[gidx_s].data;
            rd       = slot_e[gidx_s].rd;
            result_v = 1'b1;
        end else begin
            result_v = 1'b0;
        end
    end

endmodule
